// File: rtl/exe_stage_mdu.sv
// Execute stage with built-in EX/MEM register: forwarding, immediate select, single-cycle ALU
// and an iterative radix-2 multiply/divide unit that holds upstream through ex_busy.
module exe_stage_mdu #(
    parameter int XLEN       = 32,
    parameter int PC_W       = 15,
    parameter bit ENABLE_MDU = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            valid_in,
    input  logic            flush,
    input  logic            mem_stall,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [3:0]      alu_op,
    input  logic [1:0]      fwd_a,
    input  logic [1:0]      fwd_b,
    input  logic [XLEN-1:0] fwd_exmem,
    input  logic [XLEN-1:0] fwd_memwb,
    input  logic [3:0]      mem_read_in,
    input  logic [3:0]      mem_write_in,
    input  logic [1:0]      mem_to_reg_in,
    input  logic            reg_write_in,
    input  logic [4:0]      rd_in,
    input  logic [PC_W-1:0] pc_in,
    output logic            ex_busy,
    output logic            valid_out,
    output logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] write_data,
    output logic            zero,
    output logic [3:0]      mem_read_out,
    output logic [3:0]      mem_write_out,
    output logic [1:0]      mem_to_reg_out,
    output logic            reg_write_out,
    output logic [4:0]      rd_out,
    output logic [PC_W-1:0] pc_out
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, dvs_q, dvs_d;
    logic            div_q, div_d, hi_q, hi_d;

    logic            valid_q, valid_d, zero_q, zero_d, rw_q, rw_d;
    logic [XLEN-1:0] result_q, result_d, wdata_q, wdata_d;
    logic [3:0]      mr_q, mr_d, mw_q, mw_d;
    logic [1:0]      m2r_q, m2r_d;
    logic [4:0]      rd_q, rd_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic [XLEN-1:0] op_a, fwd_b_val, op_b, alu_y, mdu_res, ld_res;
    logic [SHW-1:0]  shamt;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic            is_mdu, start;

    always_comb begin
        case (fwd_a)
            2'b01:   op_a = fwd_memwb;
            2'b10:   op_a = fwd_exmem;
            default: op_a = rs1_data;
        endcase
        case (fwd_b)
            2'b01:   fwd_b_val = fwd_memwb;
            2'b10:   fwd_b_val = fwd_exmem;
            default: fwd_b_val = rs2_data;
        endcase
        op_b  = alu_src ? imm : fwd_b_val;
        shamt = op_b[SHW-1:0];
    end

    // Ops 10-13 yield 0 here; with the MDU enabled they never take this path.
    always_comb begin
        alu_y = '0;
        case (alu_op)
            4'd0:  alu_y = op_a + op_b;
            4'd1:  alu_y = op_a - op_b;
            4'd2:  alu_y = op_a & op_b;
            4'd3:  alu_y = op_a | op_b;
            4'd4:  alu_y = op_a ^ op_b;
            4'd5:  alu_y = op_a << shamt;
            4'd6:  alu_y = op_a >> shamt;
            4'd7:  alu_y = $unsigned($signed(op_a) >>> shamt);
            4'd8:  alu_y = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'd9:  alu_y = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'd10, 4'd11, 4'd12, 4'd13: alu_y = '0;
            default: alu_y = op_b;
        endcase
    end

    assign is_mdu  = ENABLE_MDU && (alu_op >= 4'd10) && (alu_op <= 4'd13);
    assign start   = (state_q == S_IDLE) && valid_in && is_mdu && !flush;
    assign ex_busy = reset_n && (start || (state_q == S_BUSY));

    // acc/lo form the 2*XLEN product (hi/lo) or the remainder/quotient pair.
    assign mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    assign div_shift = {acc_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, dvs_q};
    assign mdu_res   = hi_q ? acc_q : lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        dvs_d   = dvs_q;
        div_d   = div_q;
        hi_d    = hi_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    acc_d   = '0;
                    lo_d    = op_a;
                    dvs_d   = op_b;
                    div_d   = alu_op[2];
                    hi_d    = alu_op[0];
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (div_q) begin
                    // remainder stays below the divisor, so the borrow bit is the compare
                    if (!div_diff[XLEN]) begin
                        acc_d = div_diff[XLEN-1:0];
                        lo_d  = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[XLEN-1:0];
                        lo_d  = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[XLEN:1];
                    lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                if (!mem_stall) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    assign ld_res = (state_q == S_DONE) ? mdu_res : alu_y;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        wdata_d  = wdata_q;
        zero_d   = zero_q;
        mr_d     = mr_q;
        mw_d     = mw_q;
        m2r_d    = m2r_q;
        rw_d     = rw_q;
        rd_d     = rd_q;
        pc_d     = pc_q;
        if (flush || (!mem_stall && !((state_q == S_DONE) ||
                      ((state_q == S_IDLE) && valid_in && !start)))) begin
            valid_d = 1'b0;
            rw_d    = 1'b0;
            mr_d    = '0;
            mw_d    = '0;
        end else if (!mem_stall) begin
            valid_d  = 1'b1;
            result_d = ld_res;
            wdata_d  = fwd_b_val;
            zero_d   = (ld_res == '0);
            mr_d     = mem_read_in;
            mw_d     = mem_write_in;
            m2r_d    = mem_to_reg_in;
            rw_d     = reg_write_in;
            rd_d     = rd_in;
            pc_d     = pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            dvs_q    <= '0;
            div_q    <= 1'b0;
            hi_q     <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            wdata_q  <= '0;
            zero_q   <= 1'b0;
            mr_q     <= '0;
            mw_q     <= '0;
            m2r_q    <= '0;
            rw_q     <= 1'b0;
            rd_q     <= '0;
            pc_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            dvs_q    <= dvs_d;
            div_q    <= div_d;
            hi_q     <= hi_d;
            valid_q  <= valid_d;
            result_q <= result_d;
            wdata_q  <= wdata_d;
            zero_q   <= zero_d;
            mr_q     <= mr_d;
            mw_q     <= mw_d;
            m2r_q    <= m2r_d;
            rw_q     <= rw_d;
            rd_q     <= rd_d;
            pc_q     <= pc_d;
        end
    end

    assign valid_out      = valid_q;
    assign alu_result     = result_q;
    assign write_data     = wdata_q;
    assign zero           = zero_q;
    assign mem_read_out   = mr_q;
    assign mem_write_out  = mw_q;
    assign mem_to_reg_out = m2r_q;
    assign reg_write_out  = rw_q;
    assign rd_out         = rd_q;
    assign pc_out         = pc_q;

endmodule

// File: tb/tb_exe_stage_mdu.sv
// Self-checking bench for exe_stage_mdu: directed steps plus randomized ALU/MDU traffic
// compared against a plain-arithmetic reference model.
module tb_exe_stage_mdu;
    localparam int XLEN = 32;
    localparam int PC_W = 15;

    logic            clk = 1'b0;
    logic            reset_n, valid_in, flush, mem_stall, alu_src, reg_write_in;
    logic [31:0]     rs1_data, rs2_data, imm, fwd_exmem, fwd_memwb;
    logic [3:0]      alu_op, mem_read_in, mem_write_in;
    logic [1:0]      fwd_a, fwd_b, mem_to_reg_in;
    logic [4:0]      rd_in;
    logic [PC_W-1:0] pc_in;
    logic            ex_busy, valid_out, zero, reg_write_out;
    logic [31:0]     alu_result, write_data;
    logic [3:0]      mem_read_out, mem_write_out;
    logic [1:0]      mem_to_reg_out;
    logic [4:0]      rd_out;
    logic [PC_W-1:0] pc_out;

    exe_stage_mdu #(.XLEN(XLEN), .PC_W(PC_W), .ENABLE_MDU(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .flush(flush),
        .mem_stall(mem_stall), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .alu_src(alu_src), .alu_op(alu_op), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .fwd_exmem(fwd_exmem), .fwd_memwb(fwd_memwb), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .reg_write_in(reg_write_in), .rd_in(rd_in), .pc_in(pc_in), .ex_busy(ex_busy),
        .valid_out(valid_out), .alu_result(alu_result), .write_data(write_data),
        .zero(zero), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .rd_out(rd_out), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0]     e_res, e_wd, a_v, fb_v, b_v;
    logic            e_zero, e_valid, e_rw;
    logic [3:0]      e_mr, e_mw;
    logic [1:0]      e_m2r;
    logic [4:0]      e_rd;
    logic [PC_W-1:0] e_pc;
    int              opi, cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r,
                                         input logic [31:0] mw, input logic [31:0] em);
        if (s == 2'b01) return mw;
        if (s == 2'b10) return em;
        return r;
    endfunction

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        int sh;
        p  = 64'(a) * 64'(b);
        sh = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return $unsigned($signed(a) >>> sh);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd13: return (b == 32'd0) ? a : a % b;
            default: return b;
        endcase
    endfunction

    task automatic set_instr(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_in = 1'b1; flush = 1'b0; mem_stall = 1'b0;
        alu_op = op; rs1_data = a; rs2_data = b; fwd_a = 2'b00; fwd_b = 2'b00; alu_src = 1'b0;
        imm = $urandom; fwd_exmem = $urandom; fwd_memwb = $urandom;
        mem_read_in = 4'($urandom); mem_write_in = 4'($urandom);
        mem_to_reg_in = 2'($urandom); reg_write_in = 1'b1;
        rd_in = 5'($urandom); pc_in = PC_W'($urandom);
    endtask

    // Issues one MDU op and measures busy length, result latency and value.
    task automatic run_mdu(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        int busy, first;
        logic [31:0] exp;
        logic [4:0] rd_e;
        exp = ref_op(op, a, b);
        set_instr(op, a, b);
        rd_e = rd_in;
        busy = 0;
        first = -1;
        for (int n = 0; n < XLEN + 8 && first < 0; n++) begin
            #1;
            if (ex_busy === 1'b1) busy++;
            @(posedge clk);
            #1;
            if (valid_out === 1'b1) first = n + 1;
        end
        chk({tag, "_busy_cycles"}, 64'(busy), 64'(XLEN + 1));
        chk({tag, "_result_cycle"}, 64'(first), 64'(XLEN + 2));
        chk({tag, "_result"}, alu_result, exp);
        chk({tag, "_rd"}, rd_out, rd_e);
        valid_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        // reset dominates a live MDU instruction
        reset_n = 1'b0;
        set_instr(4'd10, 32'd3, 32'd4);
        tick();
        tick();
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_result", alu_result, 32'd0);
        chk("rst_wdata", write_data, 32'd0);
        chk("rst_ctrl", {zero, mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out, rd_out, pc_out}, 64'd0);
        chk("rst_busy", ex_busy, 1'b0);
        reset_n = 1'b1;

        // ADD with EX/MEM forwarding on B
        set_instr(4'd0, 32'd5, 32'd0);
        fwd_b = 2'b10; fwd_exmem = 32'd9; rd_in = 5'd3;
        #1 chk("add_busy", ex_busy, 1'b0);
        tick();
        chk("add_valid", valid_out, 1'b1);
        chk("add_result", alu_result, 32'd14);
        chk("add_zero", zero, 1'b0);
        chk("add_wdata", write_data, 32'd9);
        chk("add_rd", rd_out, 5'd3);

        // immediate wins over forwarded B, store data keeps forwarded B
        set_instr(4'd0, 32'd1, 32'd0);
        alu_src = 1'b1; imm = 32'h10; fwd_b = 2'b01; fwd_memwb = 32'hAB;
        tick();
        chk("imm_result", alu_result, 32'h11);
        chk("imm_wdata", write_data, 32'hAB);

        set_instr(4'd1, 32'd7, 32'd7);
        tick();
        chk("sub_zero", zero, 1'b1);
        chk("sub_result", alu_result, 32'd0);

        // randomized single-cycle traffic with stalls, bubbles and flushes
        for (int i = 0; i < 60; i++) begin
            valid_in  = (i == 0) ? 1'b1 : ($urandom_range(0, 5) != 0);
            mem_stall = (i != 0) && ($urandom_range(0, 4) == 0);
            flush     = (i != 0) && ($urandom_range(0, 7) == 0);
            opi = int'($urandom_range(0, 11));
            if (opi >= 10) opi += 4;
            alu_op = 4'(opi);
            rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
            fwd_exmem = $urandom; fwd_memwb = $urandom;
            fwd_a = 2'($urandom_range(0, 3)); fwd_b = 2'($urandom_range(0, 3));
            alu_src = 1'($urandom_range(0, 1));
            mem_read_in = 4'($urandom); mem_write_in = 4'($urandom);
            mem_to_reg_in = 2'($urandom); reg_write_in = 1'($urandom);
            rd_in = 5'($urandom); pc_in = PC_W'($urandom);
            a_v  = pick(fwd_a, rs1_data, fwd_memwb, fwd_exmem);
            fb_v = pick(fwd_b, rs2_data, fwd_memwb, fwd_exmem);
            b_v  = alu_src ? imm : fb_v;
            if (flush || (!mem_stall && !valid_in)) begin
                e_valid = 1'b0; e_rw = 1'b0; e_mr = 4'd0; e_mw = 4'd0;
            end else if (!mem_stall) begin
                e_valid = 1'b1; e_res = ref_op(alu_op, a_v, b_v); e_wd = fb_v;
                e_zero = (e_res == 32'd0); e_rw = reg_write_in; e_mr = mem_read_in;
                e_mw = mem_write_in; e_m2r = mem_to_reg_in; e_rd = rd_in; e_pc = pc_in;
            end
            #1 chk("rnd_busy", ex_busy, 1'b0);
            tick();
            chk("rnd_valid", valid_out, e_valid);
            chk("rnd_flags", {reg_write_out, mem_read_out, mem_write_out}, {e_rw, e_mr, e_mw});
            if (e_valid) begin
                chk("rnd_result", alu_result, e_res);
                chk("rnd_wdata", write_data, e_wd);
                chk("rnd_zero", zero, e_zero);
                chk("rnd_ctrl", {mem_to_reg_out, rd_out, pc_out}, {e_m2r, e_rd, e_pc});
            end
        end
        flush = 1'b0; mem_stall = 1'b0; valid_in = 1'b0;
        tick();

        // directed multiply/divide including divide by zero
        run_mdu("mul", 4'd10, 32'd7, 32'd6);
        run_mdu("mulhu", 4'd11, 32'hFFFF_FFFF, 32'd2);
        run_mdu("divu", 4'd12, 32'd100, 32'd7);
        run_mdu("remu", 4'd13, 32'd100, 32'd7);
        run_mdu("divu0", 4'd12, 32'd5, 32'd0);
        run_mdu("remu0", 4'd13, 32'd5, 32'd0);
        for (int i = 0; i < 6; i++) begin
            opi = 10 + int'($urandom_range(0, 3));
            run_mdu("mdu_rnd", 4'(opi), $urandom, (i == 2) ? 32'd0 : $urandom >> $urandom_range(0, 31));
        end

        // flush in BUSY cycle 10, then a plain ADD
        set_instr(4'd10, $urandom, $urandom);
        repeat (10) tick();
        #1 chk("fl_busy_before", ex_busy, 1'b1);
        flush = 1'b1;
        tick();
        set_instr(4'd0, 32'd2, 32'd3);
        #1 chk("fl_busy_after", ex_busy, 1'b0);
        chk("fl_valid", valid_out, 1'b0);
        tick();
        chk("fl_add_valid", valid_out, 1'b1);
        chk("fl_add_result", alu_result, 32'd5);
        valid_in = 1'b0;
        cnt = 0;
        repeat (XLEN + 4) begin tick(); if (valid_out === 1'b1) cnt++; end
        chk("fl_no_late_result", 64'(cnt), 64'd0);

        // mem_stall held for three cycles across DONE
        a_v = $urandom; b_v = $urandom >> 8;
        set_instr(4'd12, a_v, b_v);
        repeat (XLEN + 1) tick();
        #1 chk("st_done_busy", ex_busy, 1'b0);
        mem_stall = 1'b1;
        cnt = 0;
        repeat (3) begin tick(); if (valid_out === 1'b1) cnt++; end
        chk("st_hold_valid", 64'(cnt), 64'd0);
        mem_stall = 1'b0;
        tick();
        chk("st_valid", valid_out, 1'b1);
        chk("st_result", alu_result, ref_op(4'd12, a_v, b_v));
        valid_in = 1'b0;
        tick();
        chk("st_once", valid_out, 1'b0);

        // reset in the middle of a divide
        set_instr(4'd12, 32'd1000, 32'd3);
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        chk("mrst_valid", valid_out, 1'b0);
        chk("mrst_result", alu_result, 32'd0);
        chk("mrst_ctrl", {write_data, zero, reg_write_out, rd_out}, 64'd0);
        chk("mrst_busy", ex_busy, 1'b0);
        reset_n = 1'b1;
        valid_in = 1'b0;
        cnt = 0;
        repeat (XLEN + 4) begin tick(); if (valid_out === 1'b1) cnt++; end
        chk("mrst_no_result", 64'(cnt), 64'd0);
        set_instr(4'd0, 32'd20, 32'd22);
        #1 chk("mrst_idle_busy", ex_busy, 1'b0);
        tick();
        chk("mrst_add_result", alu_result, 32'd42);
        chk("mrst_add_valid", valid_out, 1'b1);
        valid_in = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exe_stage_mdu.md
Name: exe_stage_mdu

Overview:
- Parametrised execute stage with the EX/MEM pipeline register built in.
- Resolves operand forwarding, applies the immediate select and runs single-cycle ALU ops.
- Adds an iterative multiply/divide unit that stalls upstream while it works.
- Sits between ID/EX and the MEM stage; drives the hazard unit through ex_busy.

Parameters:
XLEN, 32, datapath width (power of two, >= 8)
PC_W, 15, width of the carried PC
ENABLE_MDU, 1, 1 = multi-cycle ops 10-13 implemented; 0 = those ops return 0 in a single cycle

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous active-low reset
valid_in  in  1  ID/EX holds a live instruction
flush  in  1  kill the in-flight instruction and load a bubble
mem_stall  in  1  MEM stage cannot accept; hold the EX/MEM register
rs1_data, rs2_data  in  XLEN  register operands from ID/EX
imm  in  XLEN  immediate
alu_src  in  1  1 = ALU B uses imm
alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL(low), 11 MULHU, 12 DIVU, 13 REMU, 14-15 pass B
fwd_a, fwd_b  in  2  00 register, 01 MEM/WB, 10 EX/MEM, 11 treated as 00
fwd_exmem, fwd_memwb  in  XLEN  forwarding values
mem_read_in, mem_write_in  in  4  byte-lane controls
mem_to_reg_in  in  2  WB select
reg_write_in  in  1  WB enable
rd_in  in  5  destination register
pc_in  in  PC_W  instruction PC
ex_busy  out  1  combinational; upstream must hold ID/EX
valid_out  out  1  EX/MEM holds a live instruction
alu_result  out  XLEN  registered result
write_data  out  XLEN  registered store data (forwarded rs2)
zero  out  1  registered (result == 0)
mem_read_out, mem_write_out, mem_to_reg_out, reg_write_out, rd_out, pc_out  out  as inputs  registered control

Behaviour:
- Reset (reset_n=0 at a clock edge): every output register is 0 and the FSM goes to IDLE. ex_busy=0 during reset.
- Operand selection:
  - opA = fwd_a mux of rs1.
  - fwdB = fwd_b mux of rs2.
  - opB = alu_src ? imm : fwdB. Forwarding is applied before the immediate select.
  - write_data = fwdB.
- Shifts use opB[log2(XLEN)-1:0]. SLT is signed, SLTU unsigned; result is 0 or 1. Arithmetic wraps modulo 2^XLEN.
- Single-cycle ops (alu_op not 10-13, or ENABLE_MDU=0): instruction presented in cycle C0 -> EX/MEM loaded at the end of C0, valid_out=1 in C1. ex_busy=0.
- FSM IDLE / BUSY / DONE, used for ops 10-13 with ENABLE_MDU=1:
  - IDLE: when valid_in and an MDU op are present and there is no flush, latch opA/opB, clear the counter, go to BUSY. ex_busy=1 this cycle.
  - BUSY: one radix-2 step per cycle (shift-add multiply with a 2*XLEN product; restoring divide). Runs XLEN cycles, then DONE. ex_busy=1.
  - DONE: ex_busy=0. When mem_stall=0, load the result plus the current control inputs into EX/MEM and go to IDLE. Otherwise stay in DONE.
  - Timing: ex_busy=1 in C0..C_XLEN, valid_out=1 in C_{XLEN+2}.
- EX/MEM load while not in DONE and the FSM is not idle: a bubble is loaded (valid_out, reg_write_out, mem_read_out, mem_write_out = 0) unless mem_stall=1.
- MDU results:
  - MUL = low XLEN bits of the product; MULHU = high XLEN bits.
  - Divide by zero: DIVU = all ones, REMU = dividend. Computed by the normal iteration; no early exit.
- mem_stall=1: the EX/MEM register holds all values. The BUSY iteration keeps running; DONE waits. mem_stall is not folded into ex_busy.
- flush=1 (priority over mem_stall and start):
  - EX/MEM loads a bubble.
  - FSM goes to IDLE and any partial result is discarded.
  - ex_busy=0 in the following cycle.
- valid_in=0: the instruction is treated as a bubble; the FSM does not start.
- Reset mid-operation: the FSM goes to IDLE, outputs clear, no result is emitted.

Test Plan:
- ADD with rs1=5, rs2=0, fwd_b=10, fwd_exmem=9 -> alu_result=14, zero=0, valid_out in the next cycle.
- alu_src=1, imm=0x10, fwd_b=01, fwd_memwb=0xAB, op ADD, rs1=1 -> alu_result=0x11, write_data=0xAB.
- MUL 7×6 (XLEN=32) -> ex_busy high for 33 cycles, bubbles on valid_out meanwhile, then alu_result=42 in C34; MULHU 0xFFFFFFFF×2 -> 1.
- DIVU 100/7 -> 14; REMU -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
- Start MUL, assert flush in BUSY cycle 10 -> ex_busy=0 next cycle, valid_out=0; next ADD 2+3 -> 5.
- mem_stall held 3 cycles across DONE -> result appears exactly once after release. reset_n=0 mid-DIVU -> all outputs 0, FSM IDLE.
